// File: rtl/bpred_pkg.sv
// Shared types and defaults for the branch-predictor table scheduler.
package bpred_pkg;

  localparam int DEF_IDX_W  = 4;
  localparam int DEF_CTR_W  = 2;
  localparam int DEF_QDEPTH = 4;

  // Every entry starts out weakly not-taken.
  localparam int INIT_CTR = 1;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_RD,
    UPD_WR
  } state_t;

endpackage

// File: rtl/bpred_table_sched_if.sv
// Lookup, update and external-table signals of the predictor table scheduler.
interface bpred_table_sched_if #(
  parameter int IDX_W = 4,
  parameter int CTR_W = 2
);
  logic             lk_valid;
  logic [IDX_W-1:0] lk_index;
  logic             lk_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             up_valid;
  logic [IDX_W-1:0] up_index;
  logic             up_taken;
  logic             up_ready;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [CTR_W-1:0] tbl_wdata;
  logic [CTR_W-1:0] tbl_rdata;

  modport master (
    output lk_valid, lk_index, up_valid, up_index, up_taken, tbl_rdata,
    input  lk_ready, pred_valid, pred_taken, up_ready,
    input  tbl_en, tbl_we, tbl_addr, tbl_wdata
  );

  modport slave (
    input  lk_valid, lk_index, up_valid, up_index, up_taken, tbl_rdata,
    output lk_ready, pred_valid, pred_taken, up_ready,
    output tbl_en, tbl_we, tbl_addr, tbl_wdata
  );
endinterface

// File: rtl/bpred_upd_fifo.sv
// Pending branch-resolution queue of {index, taken}; push and pop may share a cycle.
module bpred_upd_fifo #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_index,
  input  logic             push_taken,
  input  logic             pop,
  output logic [IDX_W-1:0] head_index,
  output logic             head_taken,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] idx_mem   [DEPTH];
  logic             taken_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == (PW + 1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_index = idx_mem[rd_ptr];
  assign head_taken = taken_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      idx_mem[wr_ptr]   <= push_index;
      taken_mem[wr_ptr] <= push_taken;
    end
  end

endmodule

// File: rtl/bpred_table_sched.sv
// Schedules lookups and queued counter updates onto a single-port external
// predictor table; lookups win unless the update queue is full.
module bpred_table_sched
  import bpred_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CTR_W  = DEF_CTR_W,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  bpred_table_sched_if.slave   bus,
  output logic [15:0]          upd_count
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] init_addr;
  logic [CTR_W-1:0] new_ctr;
  logic             pred_r;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic [IDX_W-1:0] head_index;
  logic             head_taken;

  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] cur,
                                                 input logic taken);
    if (taken) return (cur == {CTR_W{1'b1}}) ? cur : cur + 1'b1;
    return (cur == '0) ? cur : cur - 1'b1;
  endfunction

  bpred_upd_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_index (bus.up_index),
    .push_taken (bus.up_taken),
    .pop        (q_pop),
    .head_index (head_index),
    .head_taken (head_taken),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign q_push         = bus.up_valid && bus.up_ready;
  assign bus.pred_valid = pred_r && !rst;
  assign bus.pred_taken = pred_r && !rst && bus.tbl_rdata[CTR_W-1];

  // Outputs are held quiet while reset is asserted so an abandoned
  // read-modify-write never reaches the table.
  always_comb begin
    state_nxt     = state;
    bus.lk_ready  = 1'b0;
    bus.up_ready  = 1'b0;
    bus.tbl_en    = 1'b0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;
    q_pop         = 1'b0;
    if (!rst) begin
      bus.up_ready = !q_full && (state != INIT);
      unique case (state)
        INIT: begin
          bus.tbl_en    = 1'b1;
          bus.tbl_we    = 1'b1;
          bus.tbl_addr  = init_addr;
          bus.tbl_wdata = CTR_W'(INIT_CTR);
          if (init_addr == {IDX_W{1'b1}}) state_nxt = IDLE;
        end
        IDLE: begin
          if (q_full || (!q_empty && !bus.lk_valid)) begin
            bus.tbl_en   = 1'b1;
            bus.tbl_addr = head_index;
            state_nxt    = UPD_RD;
          end else if (bus.lk_valid) begin
            bus.lk_ready = 1'b1;
            bus.tbl_en   = 1'b1;
            bus.tbl_addr = bus.lk_index;
          end
        end
        UPD_RD: state_nxt = UPD_WR;
        UPD_WR: begin
          bus.tbl_en    = 1'b1;
          bus.tbl_we    = 1'b1;
          bus.tbl_addr  = head_index;
          bus.tbl_wdata = new_ctr;
          q_pop         = 1'b1;
          state_nxt     = IDLE;
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  // The init address wraps back to zero on its own once the sweep ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_addr <= '0;
      new_ctr   <= '0;
      pred_r    <= 1'b0;
      upd_count <= '0;
    end else begin
      state  <= state_nxt;
      pred_r <= bus.lk_ready;
      if (state == INIT)   init_addr <= init_addr + 1'b1;
      if (state == UPD_RD) new_ctr   <= sat_step(bus.tbl_rdata, head_taken);
      if (state == UPD_WR) upd_count <= upd_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_bpred_table_sched.sv
// Self-checking bench: external table model, write/prediction scoreboards,
// a vector table and hand sequences for starvation and mid-update reset.
module tb_bpred_table_sched;
  import bpred_pkg::*;

  typedef struct {
    logic [3:0] addr;
    logic [1:0] data;
  } wr_t;

  typedef struct {
    bit         is_lookup;
    logic [3:0] idx;
    logic       taken;
    int         exp_out;
    int         exp_count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] upd_count;

  bpred_table_sched_if #(.IDX_W(4), .CTR_W(2)) bus ();

  bpred_table_sched #(.IDX_W(4), .CTR_W(2), .QDEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .upd_count (upd_count)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [16];
  logic [1:0] ref_commit [16];
  logic [1:0] ref_future [16];
  wr_t        wr_q[$];
  bit         pred_q[$];
  wr_t        wr_e;
  int         tests = 0;
  int         fails = 0;
  bit         init_phase = 1'b1;
  int         init_exp = 0;
  int         last_pred = -1;
  int         last_wdata = -1;
  vec_t       vecs [13];

  // External table: one access per cycle, read data one cycle later.
  always @(posedge clk) begin
    if (bus.tbl_en) begin
      if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
      else            bus.tbl_rdata    <= mem[bus.tbl_addr];
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input int act);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0d, required no such event", name, act);
  endtask

  function automatic logic [1:0] satModel(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Monitor: init sweep, scoreboarded update writes and predictions.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tbl_en && bus.tbl_we) begin
        if (init_phase) begin
          checkOutput("init_addr", int'(bus.tbl_addr), init_exp);
          checkOutput("init_wdata", int'(bus.tbl_wdata), 1);
          checkOutput("init_lk_ready", int'(bus.lk_ready), 0);
          checkOutput("init_up_ready", int'(bus.up_ready), 0);
          if (init_exp == 15) init_phase = 1'b0;
          init_exp++;
        end else if (wr_q.size() == 0) begin
          failNow("unexpected_write", int'(bus.tbl_addr));
        end else begin
          wr_e = wr_q.pop_front();
          checkOutput("upd_addr", int'(bus.tbl_addr), int'(wr_e.addr));
          checkOutput("upd_wdata", int'(bus.tbl_wdata), int'(wr_e.data));
          ref_commit[wr_e.addr] = wr_e.data;
          last_wdata = int'(bus.tbl_wdata);
        end
      end
      if (bus.pred_valid) begin
        if (pred_q.size() == 0) failNow("unexpected_pred", int'(bus.pred_taken));
        else checkOutput("pred_taken", int'(bus.pred_taken), int'(pred_q.pop_front()));
        last_pred = int'(bus.pred_taken);
      end
      if (bus.lk_valid && bus.lk_ready) pred_q.push_back(ref_commit[bus.lk_index][1]);
    end
  end

  task automatic doReset();
    rst = 1'b1;
    bus.lk_valid = 1'b0;
    bus.up_valid = 1'b0;
    wr_q.delete();
    pred_q.delete();
    init_phase = 1'b1;
    init_exp = 0;
    for (int i = 0; i < 16; i++) begin
      ref_commit[i] = 2'b01;
      ref_future[i] = 2'b01;
    end
    @(negedge clk);
    checkOutput("rst_tbl_en", int'(bus.tbl_en), 0);
    checkOutput("rst_tbl_we", int'(bus.tbl_we), 0);
    checkOutput("rst_up_ready", int'(bus.up_ready), 0);
    checkOutput("rst_lk_ready", int'(bus.lk_ready), 0);
    checkOutput("rst_pred_valid", int'(bus.pred_valid), 0);
    checkOutput("rst_upd_count", int'(upd_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitInit();
    bit ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!init_phase) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("init_timeout", init_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (wr_q.size() == 0 && pred_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("drain_timeout", wr_q.size() + pred_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic pushUpdate(input logic [3:0] idx, input logic tk);
    logic [1:0] nv;
    bit ok = 1'b0;
    bus.up_index = idx;
    bus.up_taken = tk;
    bus.up_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.up_ready) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("up_ready_timeout", 0);
    else begin
      nv = satModel(ref_future[idx], tk);
      ref_future[idx] = nv;
      wr_q.push_back('{addr: idx, data: nv});
    end
    @(posedge clk);
    #1 bus.up_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bit ok = 1'b0;
    if (v.is_lookup) begin
      bus.lk_index = v.idx;
      bus.lk_valid = 1'b1;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (bus.lk_ready) begin ok = 1'b1; break; end
      end
      if (!ok) failNow("lk_ready_timeout", 0);
      @(posedge clk);
      #1 bus.lk_valid = 1'b0;
    end else begin
      pushUpdate(v.idx, v.taken);
    end
    drain();
  endtask

  task automatic checkVector(input int n, input vec_t v);
    if (v.is_lookup) checkOutput($sformatf("vec%0d_pred", n), last_pred, v.exp_out);
    else             checkOutput($sformatf("vec%0d_wdata", n), last_wdata, v.exp_out);
    checkOutput($sformatf("vec%0d_upd_count", n), int'(upd_count), v.exp_count);
  endtask

  initial begin
    #200000;
    failNow("global_timeout", 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int first_ready;
    vecs[0]  = '{1'b1, 4'd3, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 4'd3, 1'b1, 2, 1};
    vecs[2]  = '{1'b0, 4'd3, 1'b1, 3, 2};
    vecs[3]  = '{1'b0, 4'd3, 1'b1, 3, 3};
    vecs[4]  = '{1'b1, 4'd3, 1'b0, 1, 3};
    vecs[5]  = '{1'b0, 4'd5, 1'b0, 0, 4};
    vecs[6]  = '{1'b0, 4'd5, 1'b0, 0, 5};
    vecs[7]  = '{1'b1, 4'd5, 1'b0, 0, 5};
    vecs[8]  = '{1'b0, 4'd7, 1'b1, 2, 6};
    vecs[9]  = '{1'b1, 4'd7, 1'b0, 1, 6};
    vecs[10] = '{1'b0, 4'd7, 1'b0, 1, 7};
    vecs[11] = '{1'b1, 4'd7, 1'b0, 0, 7};
    vecs[12] = '{1'b0, 4'd7, 1'b0, 0, 8};

    bus.lk_index = '0;
    bus.up_index = '0;
    bus.up_taken = 1'b0;
    doReset();

    // Init sweep takes 16 cycles; the first lookup is accepted on cycle 17.
    bus.lk_index = 4'd0;
    bus.lk_valid = 1'b1;
    first_ready = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (bus.lk_ready) begin first_ready = c; break; end
    end
    checkOutput("first_lk_ready_cycle", first_ready, 17);
    @(posedge clk);
    #1 bus.lk_valid = 1'b0;
    drain();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Lookups held high while the queue fills; the full queue forces an update.
    bus.lk_index = 4'd8;
    bus.lk_valid = 1'b1;
    pushUpdate(4'd8, 1'b1);
    pushUpdate(4'd9, 1'b1);
    pushUpdate(4'd10, 1'b0);
    pushUpdate(4'd8, 1'b1);
    @(negedge clk);
    checkOutput("full_up_ready", int'(bus.up_ready), 0);
    checkOutput("full_lk_ready", int'(bus.lk_ready), 0);
    checkOutput("full_rd_en", int'(bus.tbl_en), 1);
    checkOutput("full_rd_we", int'(bus.tbl_we), 0);
    @(negedge clk);
    checkOutput("updrd_lk_ready", int'(bus.lk_ready), 0);
    checkOutput("updrd_up_ready", int'(bus.up_ready), 0);
    checkOutput("updrd_tbl_en", int'(bus.tbl_en), 0);
    @(negedge clk);
    checkOutput("updwr_lk_ready", int'(bus.lk_ready), 0);
    checkOutput("updwr_tbl_we", int'(bus.tbl_we), 1);
    checkOutput("updwr_up_ready", int'(bus.up_ready), 0);
    @(negedge clk);
    checkOutput("popped_up_ready", int'(bus.up_ready), 1);
    checkOutput("popped_lk_ready", int'(bus.lk_ready), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("lookup_priority", int'(bus.lk_ready), 1);
    end
    @(posedge clk);
    #1 bus.lk_valid = 1'b0;
    drain();
    checkOutput("starve_upd_count", int'(upd_count), 12);
    checkOutput("ctr8_value", int'(mem[8]), 3);

    // Reset while the read-modify-write sits in UPD_RD.
    pushUpdate(4'd2, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("in_updrd_tbl_en", int'(bus.tbl_en), 0);
    checkOutput("in_updrd_lk_ready", int'(bus.lk_ready), 0);
    doReset();
    waitInit();
    checkOutput("post_rst_upd_count", int'(upd_count), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post_rst_idle_tbl_en", int'(bus.tbl_en), 0);
    end
    checkOutput("post_rst_ctr2", int'(mem[2]), 1);
    checkOutput("final_wr_q", wr_q.size(), 0);
    checkOutput("final_pred_q", pred_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bpred_table_sched.md
BPRED_TABLE_SCHED -- requirements
Module: bpred_table_sched

Interface
REQ-001 Parameter IDX_W, default 4, table index width; table holds 2^IDX_W entries.
REQ-002 Parameter CTR_W, default 2, saturating-counter width per entry.
REQ-003 Parameter QDEPTH, default 4, pending-update queue depth.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 lk_valid  in  1  lookup request.
REQ-008 lk_index  in  IDX_W  lookup index.
REQ-009 lk_ready  out  1  lookup accepted this cycle when lk_valid=1.
REQ-010 pred_valid  out  1  prediction result valid.
REQ-011 pred_taken  out  1  predicted direction (counter MSB).
REQ-012 up_valid  in  1  branch resolution push.
REQ-013 up_index  in  IDX_W  resolved branch index.
REQ-014 up_taken  in  1  resolved direction.
REQ-015 up_ready  out  1  queue can accept a push.
REQ-016 tbl_en  out  1  table access strobe.
REQ-017 tbl_we  out  1  table write enable.
REQ-018 tbl_addr  out  IDX_W  table address.
REQ-019 tbl_wdata  out  CTR_W  table write data.
REQ-020 tbl_rdata  in  CTR_W  table read data, valid one cycle after a read strobe.
REQ-021 upd_count  out  16  number of completed updates, wraps at 2^16.

Function
REQ-022 FSM states: INIT, IDLE, UPD_RD, UPD_WR.
REQ-023 INIT: one write per cycle, addr 0..2^IDX_W-1, wdata 01 (weakly not-taken); lk_ready=up_ready=0; after the last address -> IDLE.
REQ-024 IDLE, queue full, or queue non-empty with lk_valid=0: issue read of queue-head index (tbl_en=1, tbl_we=0), lk_ready=0 -> UPD_RD.
REQ-025 IDLE otherwise with lk_valid=1: lk_ready=1, read lk_index; next cycle pred_valid=1, pred_taken=tbl_rdata[CTR_W-1].
REQ-026 pred_valid SHALL be a single-cycle pulse per accepted lookup; latency exactly 1 cycle.
REQ-027 UPD_RD: capture tbl_rdata, compute new counter -> UPD_WR; lk_ready=0.
REQ-028 Counter rule: taken -> +1 saturating at 2^CTR_W-1; not-taken -> -1 saturating at 0.
REQ-029 UPD_WR: tbl_en=tbl_we=1, addr=head index, wdata=new counter; pop queue, increment upd_count -> IDLE.
REQ-030 Lookups SHALL have priority over updates unless the queue is full (starvation guard).
REQ-031 up_ready = queue not full, in all states except INIT; push and pop in the same cycle SHALL both take effect.
REQ-032 Lookup of an index with a queued update SHALL return the table value (pre-update); no forwarding.
REQ-033 At most one table access per cycle; tbl_we=0 outside INIT and UPD_WR.

Reset
REQ-034 rst=1 SHALL force state INIT with address 0, empty queue, pred_valid=0, lk_ready=0, up_ready=0, tbl_en=tbl_we=0, upd_count=0.
REQ-035 Reset mid-update SHALL abandon the read-modify-write with no write issued; queued updates are discarded.

Structure
REQ-036 Package bpred_pkg SHALL hold the FSM state enum, default IDX_W/CTR_W/QDEPTH, and the init counter constant 01.
REQ-037 Queue SHALL be sub-module bpred_upd_fifo (QDEPTH entries of {index, taken}, full/empty, simultaneous push/pop).
REQ-038 The table storage is external; this block contains no table array.

Verification (IDX_W=4, CTR_W=2, QDEPTH=4)
REQ-039 rst one cycle -> 16 cycles tbl_we=1, addr 0..15, wdata 01, lk_ready=0; lk_ready=1 on cycle 17 with lk_valid=1.
REQ-040 Lookup index 3 after init -> pred_valid=1 next cycle, pred_taken=0.
REQ-041 Three taken updates to index 3, lk_valid=0 -> writes 10, 11, 11; lookup index 3 -> pred_taken=1; upd_count=3.
REQ-042 Not-taken update to index 5 twice -> writes 00, 00 (saturation at 0).
REQ-043 lk_valid held high, push 4 updates -> up_ready=0 after 4th; lk_ready=0 for UPD_RD+UPD_WR; up_ready=1 after the pop.
REQ-044 rst during UPD_RD -> no update write follows, queue empty, INIT restarts at addr 0.
